// File: rtl/wave_capture.sv
// Captures one window of audio samples, starting at a positive-going zero crossing,
// into the half of a double-buffered display RAM that the display is not reading.
module wave_capture #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_sample_ready,
  input  logic [15:0]           new_sample_in,
  input  logic                  wave_display_idle,
  output logic [ADDR_WIDTH:0]   write_address,
  output logic                  write_enable,
  output logic [7:0]            write_sample,
  output logic                  read_index
);

  typedef enum logic [1:0] {
    ST_ARMED,
    ST_ACTIVE,
    ST_WAIT
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   count_reg, count_next;
  // Only the sign of the previous sample matters for crossing detection.
  logic                    prev_negative_reg, prev_negative_next;
  logic                    read_index_reg, read_index_next;
  logic [ADDR_WIDTH:0]     address_reg, address_next;
  logic                    enable_reg, enable_next;
  logic [7:0]              sample_reg, sample_next;

  logic                    crossing;
  logic [7:0]              converted;

  assign crossing  = new_sample_ready && prev_negative_reg && !new_sample_in[15];
  assign converted = {~new_sample_in[15], new_sample_in[14:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= ST_ARMED;
      count_reg         <= '0;
      prev_negative_reg <= 1'b0;
      read_index_reg    <= 1'b0;
      address_reg       <= '0;
      enable_reg        <= 1'b0;
      sample_reg        <= '0;
    end else begin
      state_reg         <= state_next;
      count_reg         <= count_next;
      prev_negative_reg <= prev_negative_next;
      read_index_reg    <= read_index_next;
      address_reg       <= address_next;
      enable_reg        <= enable_next;
      sample_reg        <= sample_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    count_next         = count_reg;
    read_index_next    = read_index_reg;
    address_next       = address_reg;
    enable_next        = 1'b0;
    sample_next        = sample_reg;
    prev_negative_next = new_sample_ready ? new_sample_in[15] : prev_negative_reg;

    case (state_reg)
      ST_ARMED: begin
        if (crossing) begin
          enable_next  = 1'b1;
          address_next = {~read_index_reg, {ADDR_WIDTH{1'b0}}};
          sample_next  = converted;
          count_next   = ADDR_WIDTH'(1);
          state_next   = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (new_sample_ready) begin
          enable_next  = 1'b1;
          address_next = {~read_index_reg, count_reg};
          sample_next  = converted;
          count_next   = count_reg + ADDR_WIDTH'(1);
          // Last offset of the window: count wraps to zero on its own.
          if (count_reg == {ADDR_WIDTH{1'b1}}) begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wave_display_idle) begin
          read_index_next = ~read_index_reg;
          state_next      = ST_ARMED;
        end
      end
      default: begin
        state_next = ST_ARMED;
      end
    endcase
  end

  assign write_address = address_reg;
  assign write_enable  = enable_reg;
  assign write_sample  = sample_reg;
  assign read_index    = read_index_reg;

endmodule

// File: tb/tb_wave_capture.sv
// Randomised self-checking bench for wave_capture against a phase-based capture model.
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = waiting for crossing, 1 = filling window, 2 = window full.
  int          m_phase, m_count, m_read, tcyc, n_writes;
  bit          m_prev_neg;
  logic        exp_we, exp_read;
  logic [8:0]  exp_addr;
  logic [7:0]  exp_data;

  wave_capture #(.ADDR_WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  always #5 clk = ~clk;

  task automatic model_write(input int off, input logic [15:0] s);
    exp_we   = 1'b1;
    exp_addr = 9'((m_read != 0 ? 0 : 256) + off);
    exp_data = 8'((int'(s) / 256 + 128) % 256);
  endtask

  // Applies one cycle of inputs, advances the model, samples 1 time unit after the edge.
  task automatic cycle(input logic r, input logic v, input logic [15:0] s, input logic i);
    reset = r; new_sample_ready = v; new_sample_in = s; wave_display_idle = i;
    @(posedge clk); #1;
    tcyc++;
    exp_we = 1'b0;
    if (r) begin
      m_phase = 0; m_count = 0; m_read = 0; m_prev_neg = 0;
      exp_addr = '0; exp_data = '0;
    end else begin
      case (m_phase)
        0: if (v && m_prev_neg && s < 16'h8000) begin
             model_write(0, s); m_count = 1; m_phase = 1;
           end
        1: if (v) begin
             model_write(m_count, s); m_count++;
             if (m_count == 256) begin m_count = 0; m_phase = 2; end
           end
        default: if (i) begin m_read = 1 - m_read; m_phase = 0; end
      endcase
      if (v) m_prev_neg = (s >= 16'h8000);
    end
    exp_read = (m_read != 0);
    if (write_enable === 1'b1) begin
      n_writes++;
      $display("WR t=%0d addr=%h data=%h ri=%b", tcyc, write_address, write_sample, read_index);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 1'b1, (k == 0) ? 16'h8000 : 16'h0100, 1'b1);
      checks++;
      if (write_enable !== 1'b0 || read_index !== 1'b0 || write_address !== 9'h000) begin
        errors++;
        $display("FAIL reset_hold we=%b ri=%b addr=%h required 0 0 000", write_enable, read_index, write_address);
      end
    end
    cycle(1'b0, 1'b1, 16'h0000, 1'b0);
    checks++;
    if (write_enable !== 1'b0 || read_index !== 1'b0 || write_address !== 9'h000) begin
      errors++;
      $display("FAIL reset_release we=%b ri=%b addr=%h required 0 0 000", write_enable, read_index, write_address);
    end
  endtask

  task automatic test_basic_capture();
    logic [15:0] s;
    logic [8:0]  first_addr;
    logic [7:0]  first_data;
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    n_writes = 0; first_addr = 'x; first_data = 'x;
    for (int k = 0; k < 257; k++) begin
      s = (k == 0) ? 16'hFF00 : (k == 1) ? 16'h0100 : 16'(32'h0200 + (k - 2) * 32'h100);
      for (int c = 0; c < 4; c++) begin
        cycle(1'b0, c == 0, s, 1'b0);
        if (write_enable === 1'b1 && n_writes == 1) begin
          first_addr = write_address; first_data = write_sample;
        end
        checks++;
        if (write_enable !== exp_we || read_index !== exp_read ||
            (exp_we && (write_address !== exp_addr || write_sample !== exp_data))) begin
          errors++;
          $display("FAIL basic t=%0d we=%b exp %b addr=%h exp %h data=%h exp %h ri=%b exp %b",
                   tcyc, write_enable, exp_we, write_address, exp_addr, write_sample, exp_data, read_index, exp_read);
        end
      end
    end
    for (int c = 0; c < 20; c++) cycle(1'b0, 1'b1, 16'h0100, 1'b0);
    checks++;
    if (first_addr !== 9'h100 || first_data !== 8'h81) begin
      errors++;
      $display("FAIL basic_first addr=%h data=%h required 100 81", first_addr, first_data);
    end
    checks++;
    if (n_writes != 256 || read_index !== 1'b0) begin
      errors++;
      $display("FAIL basic_count writes=%0d ri=%b required 256 0", n_writes, read_index);
    end
  endtask

  task automatic test_swap();
    int max_addr, guard;
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    checks++;
    if (read_index !== 1'b1) begin
      errors++;
      $display("FAIL swap_toggle ri=%b required 1", read_index);
    end
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      checks++;
      if (read_index !== 1'b1) begin
        errors++;
        $display("FAIL swap_once t=%0d ri=%b required 1", tcyc, read_index);
      end
    end
    n_writes = 0; max_addr = 0; guard = 0;
    cycle(1'b0, 1'b1, 16'hC000, 1'b0);
    cycle(1'b0, 1'b1, 16'h0400, 1'b0);
    while (m_phase == 1 && guard < 2000) begin
      cycle(1'b0, $urandom_range(0, 1) == 1, 16'($urandom), 1'b0);
      guard++;
      if (write_enable === 1'b1 && int'(write_address) > max_addr) max_addr = int'(write_address);
      checks++;
      if (write_enable !== exp_we || read_index !== exp_read ||
          (exp_we && (write_address !== exp_addr || write_sample !== exp_data))) begin
        errors++;
        $display("FAIL swap_capture t=%0d we=%b exp %b addr=%h exp %h data=%h exp %h ri=%b exp %b",
                 tcyc, write_enable, exp_we, write_address, exp_addr, write_sample, exp_data, read_index, exp_read);
      end
    end
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (n_writes != 256 || max_addr > 255 || guard >= 2000) begin
      errors++;
      $display("FAIL swap_half writes=%0d max_addr=%h guard=%0d required 256 <=0ff <2000", n_writes, max_addr, guard);
    end
  endtask

  task automatic test_no_false_trigger();
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    n_writes = 0;
    for (int k = 0; k < 1000; k++) cycle(1'b0, 1'b1, 16'h1000, 1'b0);
    checks++;
    if (n_writes != 0) begin
      errors++;
      $display("FAIL no_false writes=%0d required 0", n_writes);
    end
    cycle(1'b0, 1'b1, 16'h8000, 1'b0);
    cycle(1'b0, 1'b1, 16'h0000, 1'b0);
    checks++;
    if (write_enable !== 1'b1 || write_address !== 9'h100 || write_sample !== 8'h80) begin
      errors++;
      $display("FAIL no_false_start we=%b addr=%h data=%h required 1 100 80", write_enable, write_address, write_sample);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] last_addr;
    int         last_cyc;
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 16'h8000, 1'b0);
    n_writes = 0; last_addr = '0; last_cyc = 0;
    for (int k = 0; k < 300; k++) begin
      cycle(1'b0, 1'b1, (k == 0) ? 16'h0000 : 16'($urandom), 1'b0);
      checks++;
      if (write_enable !== exp_we || read_index !== exp_read ||
          (exp_we && (write_address !== exp_addr || write_sample !== exp_data))) begin
        errors++;
        $display("FAIL b2b t=%0d we=%b exp %b addr=%h exp %h data=%h exp %h",
                 tcyc, write_enable, exp_we, write_address, exp_addr, write_sample, exp_data);
      end
      if (write_enable === 1'b1) begin
        if (n_writes > 1) begin
          checks++;
          if (tcyc != last_cyc + 1 || write_address !== last_addr + 9'd1) begin
            errors++;
            $display("FAIL b2b_seq t=%0d addr=%h prev t=%0d addr=%h required consecutive", tcyc, write_address, last_cyc, last_addr);
          end
        end
        last_cyc = tcyc; last_addr = write_address;
      end
    end
    checks++;
    if (n_writes != 256 || last_addr !== 9'h1FF || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count writes=%0d last=%h we=%b required 256 1ff 0", n_writes, last_addr, write_enable);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 16'hF000, 1'b0);
    n_writes = 0;
    for (int k = 0; k < 100; k++) cycle(1'b0, 1'b1, (k == 0) ? 16'h0200 : 16'($urandom), 1'b0);
    checks++;
    if (n_writes != 100) begin
      errors++;
      $display("FAIL reset_mid_pre writes=%0d required 100", n_writes);
    end
    cycle(1'b1, 1'b1, 16'h1234, 1'b0);
    checks++;
    if (write_enable !== 1'b0 || read_index !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid we=%b ri=%b required 0 0", write_enable, read_index);
    end
    n_writes = 0;
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b1, 16'h0300, 1'b0);
    checks++;
    if (n_writes != 0) begin
      errors++;
      $display("FAIL reset_mid_abandon writes=%0d required 0", n_writes);
    end
    cycle(1'b0, 1'b1, 16'h9000, 1'b0);
    cycle(1'b0, 1'b1, 16'h7F00, 1'b0);
    checks++;
    if (write_enable !== 1'b1 || write_address !== 9'h100 || write_sample !== 8'hFF || read_index !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_restart we=%b addr=%h data=%h ri=%b required 1 100 ff 0",
               write_enable, write_address, write_sample, read_index);
    end
  endtask

  task automatic test_random();
    logic [15:0] s;
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 4000; k++) begin
      s = 16'($urandom);
      cycle(1'b0, $urandom_range(0, 2) != 0, s, $urandom_range(0, 19) == 0);
      checks++;
      if (write_enable !== exp_we || read_index !== exp_read ||
          (exp_we && (write_address !== exp_addr || write_sample !== exp_data))) begin
        errors++;
        $display("FAIL random t=%0d we=%b exp %b addr=%h exp %h data=%h exp %h ri=%b exp %b",
                 tcyc, write_enable, exp_we, write_address, exp_addr, write_sample, exp_data, read_index, exp_read);
      end
    end
  endtask

  initial begin
    tcyc = 0; n_writes = 0;
    m_phase = 0; m_count = 0; m_read = 0; m_prev_neg = 0;
    exp_we = 0; exp_read = 0; exp_addr = '0; exp_data = '0;
    reset = 1'b1; new_sample_ready = 1'b0; new_sample_in = '0; wave_display_idle = 1'b0;
    test_reset();
    test_basic_capture();
    test_swap();
    test_no_false_trigger();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
